// File: rtl/mips_kernel_core_if.sv
// mips_kernel_core_if: bundles the start/result handshake and the two shared RAM ports of
// mips_kernel_core.
//   master modport: wrapper side (drives READY/ACCEPT and the RAM read data).
//   slave  modport: kernel side (drives VALID/OUT0 and the RAM request/address/write signals).
// Parameters: IMEM_AW (instruction RAM word-address width), DMEM_AW (data RAM word-address width).
interface mips_kernel_core_if #(
    parameter int unsigned IMEM_AW = 6,
    parameter int unsigned DMEM_AW = 7
);
    logic               mips_main_READY;
    logic               mips_main_ACCEPT;
    logic               mips_main_VALID;
    logic [31:0]        mips_main_OUT0;

    logic [31:0]        mem_imem_35_q;
    logic [31:0]        mem_imem_35_d;
    logic [IMEM_AW-1:0] mem_imem_35_addr;
    logic               mem_imem_35_we;
    logic               mem_imem_35_req;

    logic [31:0]        mem_dmem_36_q;
    logic [31:0]        mem_dmem_36_d;
    logic [DMEM_AW-1:0] mem_dmem_36_addr;
    logic               mem_dmem_36_we;
    logic               mem_dmem_36_req;

    modport master (
        output mips_main_READY, mips_main_ACCEPT, mem_imem_35_q, mem_dmem_36_q,
        input  mips_main_VALID, mips_main_OUT0,
        input  mem_imem_35_d, mem_imem_35_addr, mem_imem_35_we, mem_imem_35_req,
        input  mem_dmem_36_d, mem_dmem_36_addr, mem_dmem_36_we, mem_dmem_36_req
    );

    modport slave (
        input  mips_main_READY, mips_main_ACCEPT, mem_imem_35_q, mem_dmem_36_q,
        output mips_main_VALID, mips_main_OUT0,
        output mem_imem_35_d, mem_imem_35_addr, mem_imem_35_we, mem_imem_35_req,
        output mem_dmem_36_d, mem_dmem_36_addr, mem_dmem_36_we, mem_dmem_36_req
    );
endinterface

// File: rtl/mips_kernel_core.sv
// mips_kernel_core: multi-cycle MIPS-I subset interpreter. On a READY pulse it runs the program
// held in the instruction RAM (word-addressed PC from 0) against the data RAM until syscall,
// then presents register $2 on OUT0 with VALID held high until ACCEPT.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous reset, active high; abandons any run and clears all GPRs
//   bus  - mips_kernel_core_if.slave: READY/ACCEPT/VALID/OUT0 handshake, imem and dmem
//          ports (1-cycle registered-read RAMs shared with the wrapper via req)
// Optional build macro: MIPS_MUL_EN enables SPECIAL2 mul (op 1C, funct 02); otherwise that
// encoding executes as a NOP.
module mips_kernel_core #(
    parameter int unsigned IMEM_AW = 6,
    parameter int unsigned DMEM_AW = 7
) (
    input logic             CLK,
    input logic             RST,
    mips_kernel_core_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StFwait, StExec, StMem, StMwait, StWb, StDone
    } state_e;

    localparam logic [5:0] OpSpecial  = 6'h00;
    localparam logic [5:0] OpJ        = 6'h02;
    localparam logic [5:0] OpJal      = 6'h03;
    localparam logic [5:0] OpBeq      = 6'h04;
    localparam logic [5:0] OpBne      = 6'h05;
    localparam logic [5:0] OpAddiu    = 6'h09;
    localparam logic [5:0] OpSlti     = 6'h0A;
    localparam logic [5:0] OpAndi     = 6'h0C;
    localparam logic [5:0] OpOri      = 6'h0D;
    localparam logic [5:0] OpLui      = 6'h0F;
    localparam logic [5:0] OpSpecial2 = 6'h1C;
    localparam logic [5:0] OpLw       = 6'h23;
    localparam logic [5:0] OpSw       = 6'h2B;

    state_e             state_q;
    logic [IMEM_AW-1:0] pc_q;
    logic [IMEM_AW-1:0] pc_nxt_q;
    logic [31:0]        ir_q;
    logic [31:0]        gpr_q [32];
    logic [31:0]        res_q;
    logic [4:0]         dst_q;
    logic               wen_q;
    logic               is_lw_q;

    logic               valid_q;
    logic [31:0]        out0_q;
    logic               imem_req_q;
    logic [IMEM_AW-1:0] imem_addr_q;
    logic               dmem_req_q;
    logic               dmem_we_q;
    logic [DMEM_AW-1:0] dmem_addr_q;
    logic [31:0]        dmem_d_q;

    // Instruction fields
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] rs_v, rt_v, imm_sext, imm_zext, addr_sum;
    logic [IMEM_AW-1:0] pc_inc;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign rs_v     = (rs == 5'd0) ? 32'd0 : gpr_q[rs];
    assign rt_v     = (rt == 5'd0) ? 32'd0 : gpr_q[rt];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_zext = {16'd0, ir_q[15:0]};
    assign pc_inc   = pc_q + 1'b1;
    assign addr_sum = rs_v + imm_sext;

    // Byte offset and high address bits of lw/sw are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_sum[31:DMEM_AW+2], addr_sum[1:0]};

    // Decode / execute
    logic [31:0]        alu_res;
    logic [4:0]         dst;
    logic               wen, is_lw, is_sw, is_halt;
    logic [IMEM_AW-1:0] pc_tgt;

    always_comb begin
        alu_res = 32'd0;
        dst     = rt;
        wen     = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_halt = 1'b0;
        pc_tgt  = pc_inc;
        case (op)
            OpSpecial: begin
                dst = rd;
                wen = 1'b1;
                case (funct)
                    6'h21: alu_res = rs_v + rt_v;
                    6'h23: alu_res = rs_v - rt_v;
                    6'h24: alu_res = rs_v & rt_v;
                    6'h25: alu_res = rs_v | rt_v;
                    6'h26: alu_res = rs_v ^ rt_v;
                    6'h2A: alu_res = {31'd0, $signed(rs_v) < $signed(rt_v)};
                    6'h2B: alu_res = {31'd0, rs_v < rt_v};
                    6'h00: alu_res = rt_v << shamt;
                    6'h02: alu_res = rt_v >> shamt;
                    6'h03: alu_res = $unsigned($signed(rt_v) >>> shamt);
                    6'h08: begin
                        wen    = 1'b0;
                        pc_tgt = rs_v[IMEM_AW+1:2];
                    end
                    6'h0C: begin
                        wen     = 1'b0;
                        is_halt = 1'b1;
                    end
                    default: wen = 1'b0;
                endcase
            end
            OpAddiu: begin wen = 1'b1; alu_res = rs_v + imm_sext; end
            OpAndi:  begin wen = 1'b1; alu_res = rs_v & imm_zext; end
            OpOri:   begin wen = 1'b1; alu_res = rs_v | imm_zext; end
            OpSlti:  begin wen = 1'b1; alu_res = {31'd0, $signed(rs_v) < $signed(imm_sext)}; end
            OpLui:   begin wen = 1'b1; alu_res = {ir_q[15:0], 16'd0}; end
            OpLw:    begin wen = 1'b1; is_lw = 1'b1; end
            OpSw:    is_sw = 1'b1;
            OpBeq:   if (rs_v == rt_v) pc_tgt = pc_inc + imm_sext[IMEM_AW-1:0];
            OpBne:   if (rs_v != rt_v) pc_tgt = pc_inc + imm_sext[IMEM_AW-1:0];
            OpJ:     pc_tgt = ir_q[IMEM_AW-1:0];
            OpJal: begin
                wen     = 1'b1;
                dst     = 5'd31;
                alu_res = {{(30-IMEM_AW){1'b0}}, pc_inc, 2'b00};
                pc_tgt  = ir_q[IMEM_AW-1:0];
            end
`ifdef MIPS_MUL_EN
            OpSpecial2: begin
                if (funct == 6'h02) begin
                    wen     = 1'b1;
                    dst     = rd;
                    alu_res = rs_v * rt_v;
                end
            end
`else
            OpSpecial2: ;
`endif
            default: ;
        endcase
    end

    // Sequencer with registered bus outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            pc_nxt_q    <= '0;
            ir_q        <= 32'd0;
            res_q       <= 32'd0;
            dst_q       <= 5'd0;
            wen_q       <= 1'b0;
            is_lw_q     <= 1'b0;
            valid_q     <= 1'b0;
            out0_q      <= 32'd0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            dmem_addr_q <= '0;
            dmem_d_q    <= 32'd0;
            for (int i = 0; i < 32; i++) gpr_q[i] <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.mips_main_READY) begin
                        pc_q        <= '0;
                        valid_q     <= 1'b0;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= '0;
                        state_q     <= StFetch;
                    end
                end
                StFetch: state_q <= StFwait;
                StFwait: begin
                    // RAM registered the read at the end of FETCH; q is valid now.
                    ir_q       <= bus.mem_imem_35_q;
                    imem_req_q <= 1'b0;
                    state_q    <= StExec;
                end
                StExec: begin
                    res_q    <= alu_res;
                    dst_q    <= dst;
                    wen_q    <= wen;
                    is_lw_q  <= is_lw;
                    pc_nxt_q <= pc_tgt;
                    if (is_halt) begin
                        valid_q <= 1'b1;
                        out0_q  <= gpr_q[2];
                        state_q <= StDone;
                    end else if (is_lw || is_sw) begin
                        dmem_req_q  <= 1'b1;
                        dmem_addr_q <= addr_sum[DMEM_AW+1:2];
                        dmem_we_q   <= is_sw;
                        dmem_d_q    <= is_sw ? rt_v : 32'd0;
                        state_q     <= StMem;
                    end else begin
                        state_q <= StWb;
                    end
                end
                StMem: begin
                    // Store strobe lasts exactly one cycle.
                    dmem_we_q <= 1'b0;
                    dmem_d_q  <= 32'd0;
                    if (is_lw_q) begin
                        state_q <= StMwait;
                    end else begin
                        dmem_req_q <= 1'b0;
                        state_q    <= StWb;
                    end
                end
                StMwait: begin
                    res_q      <= bus.mem_dmem_36_q;
                    dmem_req_q <= 1'b0;
                    state_q    <= StWb;
                end
                StWb: begin
                    if (wen_q && (dst_q != 5'd0)) gpr_q[dst_q] <= res_q;
                    pc_q        <= pc_nxt_q;
                    imem_req_q  <= 1'b1;
                    imem_addr_q <= pc_nxt_q;
                    state_q     <= StFetch;
                end
                StDone: begin
                    if (bus.mips_main_ACCEPT) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.mips_main_VALID  = valid_q;
    assign bus.mips_main_OUT0   = out0_q;
    assign bus.mem_imem_35_d    = 32'd0;
    assign bus.mem_imem_35_we   = 1'b0;
    assign bus.mem_imem_35_addr = imem_addr_q;
    assign bus.mem_imem_35_req  = imem_req_q;
    assign bus.mem_dmem_36_d    = dmem_d_q;
    assign bus.mem_dmem_36_addr = dmem_addr_q;
    assign bus.mem_dmem_36_we   = dmem_we_q;
    assign bus.mem_dmem_36_req  = dmem_req_q;

endmodule

// File: tb/tb_mips_kernel_core.sv
// Testbench for mips_kernel_core: directed programs plus random straight-line programs,
// checked against an instruction-level interpreter with per-class cycle costs.
module tb_mips_kernel_core;
    localparam int unsigned IMEM_AW = 6;
    localparam int unsigned DMEM_AW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_kernel_core_if #(.IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW)) bus ();

    mips_kernel_core #(.IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    logic [31:0] imem   [64];
    logic [31:0] dmem   [128];
    logic [31:0] bd_img [128];
    logic        bd_fill = 1'b0;
    logic [31:0] m_gpr  [32];
    logic [31:0] m_dmem [128];
    logic [31:0] prog   [$];

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    int we_cnt = 0;

    // RAM models: 1-cycle registered read, write on we.
    always @(posedge clk) begin
        if (bd_fill) begin
            for (int i = 0; i < 128; i++) dmem[i] <= bd_img[i];
        end else if (bus.mem_dmem_36_req) begin
            if (bus.mem_dmem_36_we) dmem[bus.mem_dmem_36_addr] <= bus.mem_dmem_36_d;
            bus.mem_dmem_36_q <= dmem[bus.mem_dmem_36_addr];
        end
        if (bus.mem_imem_35_req) bus.mem_imem_35_q <= imem[bus.mem_imem_35_addr];
    end

    // Bus-rule monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_imem_35_we) viol++;
            if (bus.mem_dmem_36_we && !bus.mem_dmem_36_req) viol++;
            if (bus.mem_imem_35_req && bus.mem_dmem_36_req) viol++;
            if (bus.mips_main_VALID && (bus.mem_imem_35_req || bus.mem_dmem_36_req)) viol++;
            if (bus.mem_dmem_36_we) we_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(int fn, int rs, int rt, int rd, int sh);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction
    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction
    function automatic logic [31:0] enc_j(int op, int tgt);
        return {op[5:0], tgt[25:0]};
    endfunction

    task automatic load_prog();
        for (int i = 0; i < 64; i++) imem[i] = (i < prog.size()) ? prog[i] : 32'd0;
    endtask

    task automatic fill_dmem(input bit rnd);
        for (int i = 0; i < 128; i++) begin
            bd_img[i] = rnd ? $urandom : 32'd0;
            m_dmem[i] = bd_img[i];
        end
        @(negedge clk) bd_fill = 1'b1;
        @(negedge clk) bd_fill = 1'b0;
    endtask

    task automatic set_dmem(input int a, input logic [31:0] v);
        bd_img[a] = v;
        m_dmem[a] = v;
        @(negedge clk) bd_fill = 1'b1;
        @(negedge clk) bd_fill = 1'b0;
    endtask

    // ISA-level interpreter; cyc counts clock edges from the READY-sampling edge to VALID.
    task automatic model_run(output logic [31:0] out, output int cyc, output int nsw);
        int pc, pc_n, addr, t;
        logic [31:0] ins, a, b, r, se, ze;
        int op, fn, rs, rt, rd, sh, dst;
        bit wr, done;
        pc = 0; cyc = 1; nsw = 0; done = 0; out = 32'hDEADBEEF;
        for (int step = 0; step < 4000 && !done; step++) begin
            ins = imem[pc];
            op = int'(ins[31:26]); fn = int'(ins[5:0]);
            rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
            sh = int'(ins[10:6]);
            a = m_gpr[rs]; b = m_gpr[rt];
            se = {{16{ins[15]}}, ins[15:0]};
            ze = {16'd0, ins[15:0]};
            pc_n = (pc + 1) % 64; wr = 0; dst = rt; r = 0;
            addr = int'(((a + se) >> 2) % 128);
            case (op)
                0: begin
                    dst = rd; wr = 1;
                    case (fn)
                        'h21: r = a + b;
                        'h23: r = a - b;
                        'h24: r = a & b;
                        'h25: r = a | b;
                        'h26: r = a ^ b;
                        'h2A: r = ($signed(a) < $signed(b)) ? 1 : 0;
                        'h2B: r = (a < b) ? 1 : 0;
                        'h00: r = b << sh;
                        'h02: r = b >> sh;
                        'h03: r = $unsigned($signed(b) >>> sh);
                        'h08: begin wr = 0; pc_n = int'((a >> 2) % 64); end
                        'h0C: begin wr = 0; done = 1; end
                        default: wr = 0;
                    endcase
                end
                'h09: begin wr = 1; r = a + se; end
                'h0C: begin wr = 1; r = a & ze; end
                'h0D: begin wr = 1; r = a | ze; end
                'h0A: begin wr = 1; r = ($signed(a) < $signed(se)) ? 1 : 0; end
                'h0F: begin wr = 1; r = {ins[15:0], 16'd0}; end
                'h23: begin wr = 1; r = m_dmem[addr]; cyc += 2; end
                'h2B: begin m_dmem[addr] = b; nsw++; cyc += 1; end
                'h04, 'h05: begin
                    if ((op == 'h04) == (a == b)) begin
                        t = pc + 1 + int'($signed(se));
                        pc_n = ((t % 64) + 64) % 64;
                    end
                end
                'h02: pc_n = int'(ins[5:0]);
                'h03: begin wr = 1; dst = 31; r = ((pc + 1) % 64) * 4; pc_n = int'(ins[5:0]); end
`ifdef MIPS_MUL_EN
                'h1C: if (fn == 2) begin wr = 1; dst = rd; r = a * b; end
`endif
                default: ;
            endcase
            if (done) begin
                out = m_gpr[2];
                cyc += 3;
            end else begin
                cyc += 4;
                if (wr && dst != 0) m_gpr[dst] = r;
                pc = pc_n;
            end
        end
        if (!done) cyc = -1;
    endtask

    task automatic run_and_check(input string tag, output logic [31:0] got);
        logic [31:0] exp_out;
        int exp_cyc, exp_sw, edges, we0, diff;
        model_run(exp_out, exp_cyc, exp_sw);
        we0 = we_cnt;
        @(negedge clk) bus.mips_main_READY = 1'b1;
        @(negedge clk) bus.mips_main_READY = 1'b0;
        edges = 1;
        while (bus.mips_main_VALID !== 1'b1 && edges < 20000) begin
            @(negedge clk);
            edges++;
        end
        got = bus.mips_main_OUT0;
        chk({tag, " cycles"}, edges, exp_cyc);
        chk({tag, " out0"}, bus.mips_main_OUT0, exp_out);
        chk({tag, " sw count"}, we_cnt - we0, exp_sw);
        diff = 0;
        for (int i = 0; i < 128; i++) if (dmem[i] !== m_dmem[i]) diff++;
        chk({tag, " dmem diffs"}, diff, 0);
        bus.mips_main_ACCEPT = 1'b1;
        @(negedge clk) bus.mips_main_ACCEPT = 1'b0;
        chk({tag, " valid after accept"}, {31'd0, bus.mips_main_VALID}, 0);
    endtask

    function automatic logic [31:0] rand_ins();
        int fns [10] = '{'h21, 'h23, 'h24, 'h25, 'h26, 'h2A, 'h2B, 'h00, 'h02, 'h03};
        int ops [5]  = '{'h09, 'h0C, 'h0D, 'h0A, 'h0F};
        int rs, rt, rd;
        rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
        case ($urandom_range(0, 6))
            0, 1: return enc_r(fns[$urandom_range(0, 9)], rs, rt, rd, $urandom_range(0, 31));
            2:    return enc_i(ops[$urandom_range(0, 4)], rs, rt, $urandom);
            3:    return enc_i('h23, rs, rt, $urandom);
            4:    return enc_i('h2B, rs, rt, $urandom);
            5:    return {6'h1C, rs[4:0], rt[4:0], rd[4:0], 5'd0, 6'h02};
            default: return enc_r('h3F, rs, rt, rd, 0);
        endcase
    endfunction

    initial begin
        logic [31:0] got;
        int sys;
        sys = 'h0C;
        bus.mips_main_READY  = 1'b0;
        bus.mips_main_ACCEPT = 1'b0;
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
        fill_dmem(1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst valid", {31'd0, bus.mips_main_VALID}, 0);
        chk("rst out0", bus.mips_main_OUT0, 0);
        chk("rst imem req", {31'd0, bus.mem_imem_35_req}, 0);
        chk("rst dmem req", {31'd0, bus.mem_dmem_36_req}, 0);
        chk("rst dmem we", {31'd0, bus.mem_dmem_36_we}, 0);
        chk("rst dmem addr", {25'd0, bus.mem_dmem_36_addr}, 0);
        rst = 1'b0;

        // 1: addiu + halt
        prog = {}; prog.push_back(enc_i('h09, 0, 2, 5)); prog.push_back(enc_r(sys, 0, 0, 0, 0));
        load_prog();
        run_and_check("t1", got);
        chk("t1 const", got, 32'd5);

        // 2: lw with negative result
        set_dmem(3, 32'd7);
        prog = {};
        prog.push_back(enc_i('h09, 0, 1, 12)); prog.push_back(enc_i('h23, 1, 2, 0));
        prog.push_back(enc_i('h09, 2, 2, -10)); prog.push_back(enc_r(sys, 0, 0, 0, 0));
        load_prog();
        run_and_check("t2", got);
        chk("t2 const", got, 32'hFFFF_FFFD);

        // 3: sum 1..10 with bne, then store
        prog = {};
        prog.push_back(enc_i('h09, 0, 1, 10)); prog.push_back(enc_i('h09, 0, 2, 0));
        prog.push_back(enc_r('h21, 2, 1, 2, 0)); prog.push_back(enc_i('h09, 1, 1, -1));
        prog.push_back(enc_i('h05, 1, 0, -3)); prog.push_back(enc_i('h2B, 0, 2, 16));
        prog.push_back(enc_r(sys, 0, 0, 0, 0));
        load_prog();
        run_and_check("t3", got);
        chk("t3 const", got, 32'd55);
        chk("t3 dmem4", dmem[4], 32'd55);

        // 4: reset mid-loop, then rerun from PC 0
        @(negedge clk) bus.mips_main_READY = 1'b1;
        @(negedge clk) bus.mips_main_READY = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        chk("t4 valid", {31'd0, bus.mips_main_VALID}, 0);
        chk("t4 reqs", {30'd0, bus.mem_imem_35_req, bus.mem_dmem_36_req}, 0);
        chk("t4 out0", bus.mips_main_OUT0, 0);
        run_and_check("t4 rerun", got);

        // 5: lui/sra, then mul
        prog = {};
        prog.push_back(enc_i('h0F, 0, 2, 'h8000)); prog.push_back(enc_r('h03, 0, 2, 2, 4));
        prog.push_back(enc_r(sys, 0, 0, 0, 0));
        load_prog();
        run_and_check("t5 sra", got);
        chk("t5 sra const", got, 32'hF800_0000);
        prog = {};
        prog.push_back(enc_i('h09, 0, 2, 1)); prog.push_back(enc_i('h09, 0, 3, 6));
        prog.push_back(enc_i('h09, 0, 4, 7)); prog.push_back({6'h1C, 5'd3, 5'd4, 5'd2, 5'd0, 6'h02});
        prog.push_back(enc_r(sys, 0, 0, 0, 0));
        load_prog();
        run_and_check("t5 mul", got);
`ifdef MIPS_MUL_EN
        chk("t5 mul const", got, 32'd42);
`else
        chk("t5 mul const", got, 32'd1);
`endif

        // jal / beq / jr control flow
        prog = {};
        prog.push_back(enc_j('h03, 3)); prog.push_back(enc_i('h09, 2, 2, 100));
        prog.push_back(enc_r(sys, 0, 0, 0, 0)); prog.push_back(enc_i('h09, 0, 2, 1));
        prog.push_back(enc_i('h04, 0, 0, 1)); prog.push_back(enc_i('h09, 2, 2, 1000));
        prog.push_back(enc_r('h08, 31, 0, 0, 0));
        load_prog();
        run_and_check("ctl", got);
        chk("ctl const", got, 32'd101);

        // 6: READY in DONE ignored, no req in DONE/IDLE
        prog = {}; prog.push_back(enc_i('h09, 0, 2, 9)); prog.push_back(enc_r(sys, 0, 0, 0, 0));
        load_prog();
        @(negedge clk) bus.mips_main_READY = 1'b1;
        @(negedge clk) bus.mips_main_READY = 1'b0;
        repeat (10) @(negedge clk);
        bus.mips_main_READY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6 done valid", {31'd0, bus.mips_main_VALID}, 1);
            chk("t6 done reqs", {30'd0, bus.mem_imem_35_req, bus.mem_dmem_36_req}, 0);
        end
        bus.mips_main_READY = 1'b0;
        chk("t6 out0", bus.mips_main_OUT0, 32'd9);
        bus.mips_main_ACCEPT = 1'b1;
        @(negedge clk) bus.mips_main_ACCEPT = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6 idle", {29'd0, bus.mips_main_VALID, bus.mem_imem_35_req,
                            bus.mem_dmem_36_req}, 0);
        end
        m_gpr[2] = 32'd9;

        // Random straight-line programs
        for (int t = 0; t < 25; t++) begin
            int len;
            fill_dmem(1'b1);
            len = $urandom_range(4, 20);
            prog = {};
            for (int i = 0; i < len; i++) prog.push_back(rand_ins());
            prog.push_back(enc_r(sys, 0, 0, 0, 0));
            load_prog();
            run_and_check("rnd", got);
        end

        chk("bus rule violations", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
